seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Sequential signed 32-by-32 divider. It is the inverse-operation companion to the sequential Booth multiplier in the arithmetic block set.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per clock, followed by a sign-fix cycle.
- Start/busy/done handshake so a controller or testbench can issue back-to-back operations.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (≥4)

Ports:
clk  input  1  rising-edge clock; the only clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  signed two's-complement dividend, captured on accepted start
divisor  input  WIDTH  signed two's-complement divisor, captured on accepted start
busy  output  1  high from the edge after accept until the edge that raises done
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  signed quotient, held until next done
remainder  output  WIDTH  signed remainder, held until next done
div_by_zero  output  1  qualifies current results; held with them

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, div_by_zero=0; quotient, remainder, and all internal registers=0. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor≠0 (edge E0):
  - Latch |dividend| into shift register Q and |divisor| into D.
  - Latch sign_q = dividend[MSB] ^ divisor[MSB] and sign_r = dividend[MSB].
  - Clear partial remainder R (WIDTH+1 bits) and the bit counter. Go to CALC; busy=1.
- IDLE, start=1, divisor=0: go to FIX with a zero flag set; busy=1.
- CALC, each edge:
  - {R,Q} shifts left 1; trial T = R_shifted − {0,D} (WIDTH+1 bits).
  - If T ≥ 0: R=T and Q[0]=1. Otherwise R is kept and Q[0]=0.
  - Counter increments. After the WIDTH-th iteration (edge E0+WIDTH) go to FIX.
- FIX, one edge:
  - quotient = sign_q ? −Q : Q; remainder = sign_r ? −R[WIDTH−1:0] : R[WIDTH−1:0].
  - done=1, busy=0, go to IDLE.
  - If the zero flag is set instead: quotient = all ones (−1), remainder = original dividend, div_by_zero=1.
  - Otherwise div_by_zero=0.
- Latency:
  - Normal: done is high in the cycle after edge E0+WIDTH+1 (33 edges after the start edge for WIDTH=32).
  - Divide-by-zero: done is high after edge E0+1.
- Semantics: truncating division (round toward zero). Remainder sign follows the dividend; |remainder| < |divisor|.
- Overflow (most-negative / −1): quotient = most-negative value (magnitude wraps), remainder = 0, div_by_zero=0. No separate flag.
- Arithmetic: magnitudes are unsigned WIDTH bits, so |most-negative| = 2^(WIDTH−1) is exact. The trial subtract is WIDTH+1 bits; its sign bit is the restore decision.
- Handshake:
  - start while busy is ignored; captured operands do not change.
  - In the done cycle the state is already IDLE, so start in that cycle is accepted. Back-to-back throughput is one result per WIDTH+2 cycles.
  - done never asserts two consecutive cycles.
  - quotient, remainder and div_by_zero change only on the edge that raises done.
- Operand inputs may change freely after the accept edge.

Decomposition:
- Shared arithmetic package:
  - state encoding constants: IDLE, CALC, FIX
  - divide-by-zero quotient constant: all ones
  - counter width function: clog2(WIDTH+1)
- One sub-module is natural: the trial subtractor, built as an instance of the team's CSA adder at WIDTH+1 bits, computing R + ~D with carry-in 1.
- Negation for the sign fix uses the same add-one form, inline.

Test Plan:
1. dividend=100, divisor=7, start one cycle → done exactly 33 edges after the start edge; quotient=14, remainder=2, div_by_zero=0; busy high for the intervening cycles.
2. Signs:
   - −100/7 → quotient=−14 (0xFFFFFFF2), remainder=−2 (0xFFFFFFFE).
   - 100/−7 → quotient=−14, remainder=2.
   - −100/−7 → quotient=14, remainder=−2.
3. 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0, div_by_zero=0. Also 0x80000000/1 → quotient=0x80000000, remainder=0.
4. 5/0 → done after edge E0+1; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. A following 9/3 → quotient=3, remainder=0, div_by_zero=0.
5. Handshake:
   - start pulsed with 50/5 during CALC of 100/7 → ignored; result is 14 r 2.
   - start held through the done cycle with 50/5 → second done 34 edges after the first start edge's done; quotient=10, remainder=0.
6. rst_n pulled low asynchronously mid-CALC (between clock edges) → busy, done, quotient and remainder are 0 immediately with no done pulse. After release, 7/2 → quotient=3, remainder=1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// divide-by-zero result constant and counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Replicated across the full width to form the all-ones (-1) quotient.
  localparam logic DBZ_QUOTIENT_BIT = 1'b1;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_csa.sv
// Adder computing a + b + cin; the divider uses it as its trial subtractor.
module seq_divider_csa #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  always_comb begin
    sum = a + b + {{(W-1){1'b0}}, cin};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per clock, followed by a single sign-fix cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // Partial remainder stays below D, so its top bit is always zero and only
  // the trial difference needs the extra sign bit.
  logic [WIDTH-1:0] r_reg;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             zero_flag;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             restore;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] q_neg;
  logic [WIDTH-1:0] r_neg;
  logic             divisor_zero;
  logic             last_iter;

  seq_divider_csa #(.W(WIDTH + 1)) u_trial (
    .a   (r_shift),
    .b   (~{1'b0, d_reg}),
    .cin (1'b1),
    .sum (trial)
  );

  always_comb begin
    r_shift      = {r_reg, q_reg[WIDTH-1]};
    restore      = trial[WIDTH];
    dividend_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    q_neg        = ~q_reg + ONE;
    r_neg        = ~r_reg + ONE;
    divisor_zero = (divisor == ZERO);
    last_iter    = (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? FIX : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = FIX;
        end else begin
          state_next = CALC;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; results move only on the edge raising done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= ZERO;
      d_reg       <= ZERO;
      r_reg       <= ZERO;
      cnt         <= {CW{1'b0}};
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_flag   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= ZERO;
      remainder   <= ZERO;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            r_reg <= ZERO;
            cnt   <= {CW{1'b0}};
            if (divisor_zero) begin
              zero_flag <= 1'b1;
              q_reg     <= dividend;
            end else begin
              zero_flag <= 1'b0;
              q_reg     <= dividend_mag;
              d_reg     <= divisor_mag;
              sign_q    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r    <= dividend[WIDTH-1];
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CALC: begin
          r_reg <= restore ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
          q_reg <= {q_reg[WIDTH-2:0], ~restore};
          cnt   <= cnt + CNT_ONE;
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zero_flag) begin
            quotient    <= {WIDTH{DBZ_QUOTIENT_BIT}};
            remainder   <= q_reg;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? q_neg : q_reg;
            remainder   <= sign_r ? r_neg : r_reg;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH=32).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Drives one start cycle; returns 1 ns after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (-1 on timeout) and cycles with busy low before it.
  task automatic wait_done(output int edges, output int busy_gap);
    bit seen;
    int i;
    seen     = 1'b0;
    i        = 0;
    busy_gap = 0;
    while (!seen && i < 100) begin
      @(posedge clk);
      #1;
      i++;
      if (done) seen = 1'b1;
      else if (!busy) busy_gap++;
    end
    edges = seen ? i : -1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int e, g;
    issue(32'd100, 32'd7);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_after_accept: got %b want 1", busy); end
    wait_done(e, g);
    n_checks++;
    if (e !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 33", e); end
    n_checks++;
    if (g !== 0) begin n_fail++; $display("FAIL basic_busy_gap: got %0d idle cycles want 0", g); end
    n_checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || quotient !== 32'd14) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: got done=%b q=%0d want done=0 q=14", done, quotient);
    end
  endtask

  task automatic test_signs;
    logic [31:0] a_tab [3] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C};
    logic [31:0] b_tab [3] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] q_tab [3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
    logic [31:0] r_tab [3] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE};
    int e, g;
    for (int k = 0; k < 3; k++) begin
      issue(a_tab[k], b_tab[k]);
      wait_done(e, g);
      n_checks++;
      if (e !== 33 || quotient !== q_tab[k] || remainder !== r_tab[k] || div_by_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL signs_%0d: got edges=%0d q=%h r=%h dbz=%b want edges=33 q=%h r=%h dbz=0",
                 k, e, quotient, remainder, div_by_zero, q_tab[k], r_tab[k]);
      end
    end
  endtask

  task automatic test_overflow;
    int e, g;
    issue(32'h80000000, 32'hFFFFFFFF);
    wait_done(e, g);
    n_checks++;
    if (quotient !== 32'h80000000 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_neg1: got q=%h r=%h dbz=%b want q=80000000 r=0 dbz=0", quotient, remainder, div_by_zero);
    end
    issue(32'h80000000, 32'd1);
    wait_done(e, g);
    n_checks++;
    if (quotient !== 32'h80000000 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL overflow_pos1: got q=%h r=%h want q=80000000 r=0", quotient, remainder);
    end
  endtask

  task automatic test_div_zero;
    int e, g;
    issue(32'd5, 32'd0);
    wait_done(e, g);
    n_checks++;
    if (e !== 1) begin n_fail++; $display("FAIL dbz_latency: got %0d edges want 1", e); end
    n_checks++;
    if (quotient !== 32'hFFFFFFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_result: got q=%h r=%h dbz=%b want q=ffffffff r=5 dbz=1", quotient, remainder, div_by_zero);
    end
    issue(32'd9, 32'd3);
    wait_done(e, g);
    n_checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_recover: got q=%0d r=%0d dbz=%b want q=3 r=0 dbz=0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    int e, g;
    issue(32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(e, g);
    n_checks++;
    if (e + 6 !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++;
      $display("FAIL ignore_start: got edges=%0d q=%0d r=%0d want edges=27 q=14 r=2", e, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int e1, e2, g;
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    dividend = 32'd50;
    divisor  = 32'd5;
    wait_done(e1, g);
    n_checks++;
    if (e1 !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_first: got edges=%0d q=%0d r=%0d want edges=33 q=14 r=2", e1, quotient, remainder);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
    end
    wait_done(e2, g);
    n_checks++;
    if (e2 + 1 !== 34 || quotient !== 32'd10 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_second: got spacing=%0d q=%0d r=%0d want spacing=34 q=10 r=0", e2 + 1, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    int e, g;
    issue(32'd9, 32'd4);
    wait_done(e, g);
    n_checks++;
    if (quotient !== 32'd2 || remainder !== 32'd1) begin
      n_fail++;
      $display("FAIL pre_reset: got q=%0d r=%0d want q=2 r=1", quotient, remainder);
    end
    issue(32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d want all zero", busy, done, quotient, remainder);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(e, g);
    n_checks++;
    if (e !== -1) begin n_fail++; $display("FAIL reset_no_done: got done after %0d edges want none", e); end
    issue(32'd7, 32'd2);
    wait_done(e, g);
    n_checks++;
    if (e !== 33 || quotient !== 32'd3 || remainder !== 32'd1) begin
      n_fail++;
      $display("FAIL post_reset: got edges=%0d q=%0d r=%0d want edges=33 q=3 r=1", e, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
